// File: rtl/cmp_share_arbiter.sv
// Shared unsigned comparator arbitrated round-robin among N_REQ requesters.
// Each accepted request walks GRANT -> EVAL -> DONE; the operands of the
// winner are captured in GRANT, compared in EVAL and reported in DONE.
module cmp_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [1:0]             res_id,
  output logic                   eq,
  output logic                   sm,
  output logic                   gr,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, GRANT, EVAL, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;     // index of the last granted requester
  logic [1:0]         win_q, win_d;     // owner of the transaction in flight
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               eq_q, eq_d;
  logic               sm_q, sm_d;
  logic               gr_q, gr_d;
  logic [1:0]         res_id_q, res_id_d;

  logic               rr_found;
  logic [1:0]         rr_idx;
  logic [1:0]         cand;

  // Unsigned compare via A + ~B + 1: carry-out means A >= B, zero means A == B.
  // Returned as {eq, sm, gr}.
  function automatic logic [2:0] cmp_unsigned(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH:0] diff;
    logic           carry;
    logic           zero;
    diff  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    carry = diff[WIDTH];
    zero  = (diff[WIDTH-1:0] == '0);
    return {zero, ~carry, carry & ~zero};
  endfunction

  // Round-robin search starting one past the last granted index, wrapping upward.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    cand     = ptr_q;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ptr_q + 2'(i);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Next-state, datapath capture and pulse outputs.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    a_d      = a_q;
    b_d      = b_q;
    eq_d     = eq_q;
    sm_d     = sm_q;
    gr_d     = gr_q;
    res_id_d = res_id_q;
    gnt      = '0;
    done     = '0;
    busy     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // DONE reports the finished transaction while already arbitrating
        // the next one, so grants can follow every third cycle.
        if (state_q == DONE) begin
          done = N_REQ'(1) << res_id_q;
        end
        if (rr_found) begin
          state_d = GRANT;
          ptr_d   = rr_idx;
          win_d   = rr_idx;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        gnt     = N_REQ'(1) << win_q;
        busy    = 1'b1;
        a_d     = a_in[int'(win_q)*WIDTH +: WIDTH];
        b_d     = b_in[int'(win_q)*WIDTH +: WIDTH];
        state_d = EVAL;
      end
      EVAL: begin
        busy                 = 1'b1;
        {eq_d, sm_d, gr_d}   = cmp_unsigned(a_q, b_q);
        res_id_d             = win_q;
        state_d              = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 2'(N_REQ - 1);
      win_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      eq_q     <= 1'b0;
      sm_q     <= 1'b0;
      gr_q     <= 1'b0;
      res_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      a_q      <= a_d;
      b_q      <= b_d;
      eq_q     <= eq_d;
      sm_q     <= sm_d;
      gr_q     <= gr_d;
      res_id_q <= res_id_d;
    end
  end

  assign eq     = eq_q;
  assign sm     = sm_q;
  assign gr     = gr_q;
  assign res_id = res_id_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Scoreboard bench for cmp_share_arbiter: a cycle-level timing model predicts
// each grant, pushes the expected result when the grant is driven, and pops it
// on the cycle the done pulse is due.
module tb_cmp_share_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n_r = 1'b0;
  logic [N-1:0]   req_r = '0;
  logic [N*W-1:0] a_r = '0;
  logic [N*W-1:0] b_r = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [1:0]     res_id;
  logic           eq, sm, gr, busy;

  cmp_share_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n_r), .req(req_r), .a_in(a_r), .b_in(b_r),
    .gnt(gnt), .done(done), .res_id(res_id), .eq(eq), .sm(sm), .gr(gr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (int'(last) + k) % 4;
      if (r[idx]) return 2'(idx);
    end
    return last;
  endfunction

  typedef struct {
    int         due;
    logic [1:0] id;
    logic       e, s, g;
  } exp_t;

  exp_t       sbq[$];
  int         gseq[$];
  logic       p_rst = 1'b0;
  logic [3:0] p_req = '0;
  int         gcyc = -100;
  logic [1:0] m_ptr = 2'd3;
  logic [1:0] h_id = '0;
  logic       h_eq = 1'b0, h_sm = 1'b0, h_gr = 1'b0;
  int         wait_cnt[4];
  logic [3:0] seen_gnt = '0;
  bit         auto_rel = 1'b1;

  // Reference model and scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    logic [3:0]  e_gnt, e_done;
    logic        e_busy;
    logic [1:0]  w;
    logic [31:0] av, bv;
    exp_t        t;
    cyc++;
    e_gnt  = '0;
    e_done = '0;
    if (!p_rst) begin
      m_ptr = 2'd3;
      gcyc  = -100;
      sbq.delete();
      h_id = '0; h_eq = 1'b0; h_sm = 1'b0; h_gr = 1'b0;
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) if (!p_req[i]) wait_cnt[i] = 0;
      if ((cyc - 1 >= gcyc + 2) && (p_req != 4'b0)) begin
        w     = rr_pick(m_ptr, p_req);
        e_gnt = 4'b1 << w;
        for (int i = 0; i < 4; i++) begin
          if (i == int'(w)) begin
            chk("fair_wait", 32'(wait_cnt[i] <= 4), 32'(1));
            wait_cnt[i] = 0;
          end else if (p_req[i]) begin
            wait_cnt[i]++;
          end
        end
        m_ptr = w;
        gcyc  = cyc;
        av    = a_r[int'(w)*W +: W];
        bv    = b_r[int'(w)*W +: W];
        t.due = cyc + 2;
        t.id  = w;
        t.e   = (av == bv);
        t.s   = (av <  bv);
        t.g   = (av >  bv);
        sbq.push_back(t);
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        t      = sbq.pop_front();
        e_done = 4'b1 << t.id;
        h_id = t.id; h_eq = t.e; h_sm = t.s; h_gr = t.g;
      end
    end
    e_busy = p_rst && (cyc == gcyc || cyc == gcyc + 1);
    chk("gnt",    32'(gnt),    32'(e_gnt));
    chk("done",   32'(done),   32'(e_done));
    chk("busy",   32'(busy),   32'(e_busy));
    chk("res_id", 32'(res_id), 32'(h_id));
    chk("eq",     32'(eq),     32'(h_eq));
    chk("sm",     32'(sm),     32'(h_sm));
    chk("gr",     32'(gr),     32'(h_gr));
    if (e_done != 4'b0) chk("one_result", 32'($countones({eq, sm, gr})), 32'(1));
    for (int i = 0; i < 4; i++) if (gnt[i]) gseq.push_back(i);
    seen_gnt = gnt;
    p_req    = req_r;
    p_rst    = rst_n_r;
  end

  // Advance to just after the next rising edge; granted requesters drop req.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_rel) req_r = req_r & ~seen_gnt;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] av;
    repeat (3) step();

    // Equal operands from requester 0 right out of reset.
    rst_n_r = 1'b1;
    req_r = 4'b0001; a_r[0*W +: W] = 32'd5; b_r[0*W +: W] = 32'd5;
    repeat (6) step();
    chk("t030_eq", 32'(eq), 32'(1));
    chk("t030_sm", 32'(sm), 32'(0));
    chk("t030_gr", 32'(gr), 32'(0));
    chk("t030_id", 32'(res_id), 32'(0));

    // Unsigned extremes on requester 1.
    req_r = 4'b0010; a_r[1*W +: W] = 32'hFFFF_FFFF; b_r[1*W +: W] = 32'h0;
    repeat (5) step();
    chk("t031_gr", 32'(gr), 32'(1));
    chk("t031_id", 32'(res_id), 32'(1));
    req_r = 4'b0010; a_r[1*W +: W] = 32'h0; b_r[1*W +: W] = 32'h1;
    repeat (5) step();
    chk("t031_sm", 32'(sm), 32'(1));
    chk("t031_id2", 32'(res_id), 32'(1));

    // Requester 1 pulses req only while the arbiter is busy: never granted.
    gseq.delete();
    req_r = 4'b0001; a_r[0*W +: W] = 32'd7; b_r[0*W +: W] = 32'd3;
    for (int k = 0; k < 20; k++) begin step(); if (seen_gnt[0]) break; end
    chk("wd_gnt0", 32'(seen_gnt[0]), 32'(1));
    req_r[1] = 1'b1;
    step();
    req_r[1] = 1'b0;
    repeat (5) step();
    chk("wd_grants", 32'(gseq.size()), 32'(1));

    // All four held high from reset: strict rotation 0,1,2,3,0.
    rst_n_r = 1'b0; auto_rel = 1'b0; req_r = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      a_r[i*W +: W] = 32'(i * 3); b_r[i*W +: W] = 32'd4;
    end
    repeat (2) step();
    gseq.delete();
    rst_n_r = 1'b1;
    repeat (16) step();
    chk("t032_len", 32'(gseq.size() >= 5), 32'(1));
    for (int i = 0; i < 5 && i < gseq.size(); i++)
      chk("t032_order", 32'(gseq[i]), 32'(i % 4));
    req_r = '0; auto_rel = 1'b1;
    repeat (6) step();

    // Operand change after GRANT must not affect the result.
    req_r = 4'b0100; a_r[2*W +: W] = 32'd10; b_r[2*W +: W] = 32'd20;
    for (int k = 0; k < 20; k++) begin step(); if (seen_gnt[2]) break; end
    chk("t033_gnt", 32'(seen_gnt[2]), 32'(1));
    a_r[2*W +: W] = 32'd100;
    repeat (3) step();
    chk("t033_sm", 32'(sm), 32'(1));
    chk("t033_id", 32'(res_id), 32'(2));

    // Reset during EVAL of requester 3.
    req_r = 4'b1000; a_r[3*W +: W] = 32'd9; b_r[3*W +: W] = 32'd1;
    for (int k = 0; k < 20; k++) begin step(); if (seen_gnt[3]) break; end
    chk("t034_gnt", 32'(seen_gnt[3]), 32'(1));
    rst_n_r = 1'b0;
    step();
    chk("t034_outs", 32'({done, gnt, busy, eq, sm, gr, res_id}), 32'(0));
    rst_n_r = 1'b1; req_r = 4'b0110;
    for (int k = 0; k < 20; k++) begin step(); if (seen_gnt != 4'b0) break; end
    chk("t034_next", 32'(seen_gnt), 32'(4'b0010));
    repeat (10) step();
    req_r = '0;
    repeat (4) step();

    // Random traffic with withdrawals and occasional resets.
    for (int c = 0; c < 32000; c++) begin
      if (n_err > 100) break;
      step();
      rst_n_r = ($urandom_range(0, 2999) != 0);
      for (int i = 0; i < 4; i++) begin
        if (seen_gnt[i]) begin
          req_r[i] = 1'b0;
        end else if (req_r[i]) begin
          if ($urandom_range(0, 63) == 0) req_r[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          av = rnd_op();
          a_r[i*W +: W] = av;
          b_r[i*W +: W] = ($urandom_range(0, 3) == 0) ? av : rnd_op();
          req_r[i] = 1'b1;
        end
      end
    end
    rst_n_r = 1'b1;
    req_r = '0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cmp_share_arbiter.md
CMP_SHARE_ARBITER -- requirements
Module: cmp_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter N_REQ, default 4, number of requesters; fixed at 4 for this release.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  N_REQ  per-requester compare request, level.
REQ-006 a_in  input  N_REQ*WIDTH  packed operand A; requester i at bits [i*WIDTH +: WIDTH].
REQ-007 b_in  input  N_REQ*WIDTH  packed operand B; same packing as a_in.
REQ-008 gnt  output  N_REQ  one-hot grant, one-cycle pulse per accepted request.
REQ-009 done  output  N_REQ  one-hot completion, one-cycle pulse.
REQ-010 res_id  output  2  index of requester owning current eq/sm/gr.
REQ-011 eq, sm, gr  output  1 each  registered result: A==B, A<B, A>B.
REQ-012 busy  output  1  high in GRANT and EVAL states.

Function
REQ-013 Single shared WIDTH-bit unsigned comparator (A + ~B + 1; carry-out and zero detect); exactly one of eq/sm/gr high once a result exists.
REQ-014 eq iff A==B; gr iff A>B unsigned; sm iff A<B unsigned; no signed interpretation.
REQ-015 FSM states: IDLE, GRANT, EVAL, DONE.
REQ-016 IDLE: req==0 -> IDLE; req!=0 -> GRANT with winner selected by round-robin.
REQ-017 Round-robin: search starts at index (last_granted+1) mod 4, wrapping upward; pointer updates only on entering GRANT.
REQ-018 GRANT (1 cycle): gnt[winner]=1; winner's a_in/b_in captured into operand registers at end of cycle; -> EVAL.
REQ-019 EVAL (1 cycle): comparator evaluates registered operands; eq/sm/gr and res_id registered at end of cycle; -> DONE.
REQ-020 DONE (1 cycle): done[res_id]=1; behaves as IDLE for arbitration (req!=0 -> GRANT, else IDLE).
REQ-021 Latency: req sampled at edge k -> gnt high cycle k+1 -> done high cycle k+3; back-to-back grants every 3 cycles.
REQ-022 Requester holds req and operands stable until gnt seen, then deasserts req next cycle; req of the current owner during EVAL/DONE is ignored for that transaction; req still high in DONE is a new request.
REQ-023 Operands are sampled only in GRANT; changes after GRANT do not affect the result.
REQ-024 eq/sm/gr/res_id hold their last value until the next EVAL completes.
REQ-025 req deasserted before gnt: request withdrawn, no grant, no error.
REQ-026 gnt and done are never high for more than one bit; gnt and done never high in the same cycle.

Reset
REQ-027 rst_n low at a rising edge: state=IDLE, pointer so req[0] has highest priority, gnt=0, done=0, eq=sm=gr=0, res_id=0, busy=0, operand registers=0.
REQ-028 Reset mid-transaction (GRANT/EVAL/DONE) discards it: no done pulse, results cleared.
REQ-029 First arbitration after reset release occurs on the first edge with rst_n high and req!=0.

Verification
REQ-030 Reset, req=4'b0001, A0=5, B0=5 -> gnt=0001 cycle 1, done=0001 cycle 3, eq=1 sm=0 gr=0, res_id=0.
REQ-031 req=4'b0010, A1=32'hFFFF_FFFF, B1=0 -> gr=1 (unsigned); A1=0, B1=1 -> sm=1, res_id=1.
REQ-032 All four req held high from reset -> grant order 0,1,2,3,0 with gnt pulses 3 cycles apart, each done index matching its gnt.
REQ-033 Requester 2 granted, then a_in[2] changed in EVAL cycle -> result reflects GRANT-cycle values.
REQ-034 rst_n low during EVAL of requester 3 -> no done pulse, all outputs 0, next grant goes to lowest active index.
REQ-035 Random 10k transactions vs. reference model: one-hot gnt/done, exactly one of eq/sm/gr, fairness (no requester waits more than 4 grants).
